// File: rtl/morse_round_ctrl_if.sv
// Controller-facing bundle between buttons, player modules and the VGA block.
// master = button/player side, slave = round controller.
interface morse_round_ctrl_if #(
  parameter int CODE_W = 10,
  parameter int ADDR_W = 4
) ();
  logic              next_n;
  logic              done_n;
  logic [CODE_W-1:0] p1_value;
  logic [CODE_W-1:0] p2_value;
  logic [1:0]        state;
  logic              tick_en;
  logic              p1_en;
  logic              p2_en;
  logic              p1_clear;
  logic              p2_clear;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W:0]   rd_ptr;
  logic [CODE_W-1:0] expected;
  logic [ADDR_W:0]   score;
  logic [ADDR_W:0]   misses;
  logic [1:0]        grade;
  logic              grade_stb;
  logic              full;
  logic              overflow;
  logic              win;

  modport master (
    output next_n, done_n, p1_value, p2_value,
    input  state, tick_en, p1_en, p2_en, p1_clear, p2_clear, wr_count, rd_ptr,
           expected, score, misses, grade, grade_stb, full, overflow, win
  );

  modport slave (
    input  next_n, done_n, p1_value, p2_value,
    output state, tick_en, p1_en, p2_en, p1_clear, p2_clear, wr_count, rd_ptr,
           expected, score, misses, grade, grade_stb, full, overflow, win
  );
endinterface

// File: rtl/morse_round_ctrl.sv
// Two-player morse round sequencer: buffers P1 codes, grades P2 guesses, keeps score.
// Button presses act 3 cycles after the raw edge; grade is registered one cycle after the decoded press.
module morse_round_ctrl #(
  parameter int CODE_W   = 10,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 25000000,
  parameter int MAX_MISS = 3
) (
  input logic              clock,
  input logic              resetn,
  morse_round_ctrl_if.slave bus
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  MISS_LIM = CNT_W'(MAX_MISS);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_P1     = 2'd1,
    ST_P2     = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   misses_q, misses_d;
  logic [1:0]         grade_q, grade_d;
  logic               overflow_q, overflow_d;
  logic               grade_stb_q, grade_stb_d;
  logic               p1_clear_q, p1_clear_d;
  logic               p2_clear_q, p2_clear_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;

  logic               next_s1_q, next_s2_q, next_s3_q;
  logic               done_s1_q, done_s2_q, done_s3_q;

  logic [CODE_W-1:0]  mem_q [DEPTH];
  logic               mem_we;

  logic               next_press;
  logic               done_press;
  logic               tick;
  logic               full;
  logic               rd_valid;
  logic [CODE_W-1:0]  expected;
  logic               guess_ok;

  // s3 holds the previous synchronised level, so a press is a 1 -> 0 step between s3 and s2
  assign next_press = next_s3_q & ~next_s2_q;
  assign done_press = done_s3_q & ~done_s2_q;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  assign full       = (wr_count_q == DEPTH_C);
  assign rd_valid   = (rd_ptr_q < wr_count_q);
  assign expected   = rd_valid ? mem_q[rd_ptr_q[ADDR_W-1:0]] : '0;
  assign guess_ok   = (bus.p2_value == expected);

  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    rd_ptr_d    = rd_ptr_q;
    score_d     = score_q;
    misses_d    = misses_q;
    grade_d     = grade_q;
    overflow_d  = overflow_q;
    grade_stb_d = 1'b0;
    p1_clear_d  = 1'b0;
    p2_clear_d  = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_START: begin
        if (done_press) begin
          state_d    = ST_P1;
          p1_clear_d = 1'b1;
          wr_count_d = '0;
          rd_ptr_d   = '0;
          score_d    = '0;
          misses_d   = '0;
          grade_d    = 2'b00;
          overflow_d = 1'b0;
        end
      end

      ST_P1: begin
        if (next_press) begin
          if (!full) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + ONE;
            p1_clear_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // DONE sees the count after a same-cycle NEXT write
        if (done_press && (wr_count_d != '0)) begin
          state_d    = ST_P2;
          rd_ptr_d   = '0;
          p2_clear_d = 1'b1;
        end
      end

      ST_P2: begin
        if (next_press) begin
          if (guess_ok) begin
            score_d = score_q + ONE;
            grade_d = 2'b01;
          end else begin
            misses_d = misses_q + ONE;
            grade_d  = 2'b10;
          end
          grade_stb_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + ONE;
          p2_clear_d  = 1'b1;
          if ((rd_ptr_d == wr_count_q) || (misses_d == MISS_LIM)) begin
            state_d = ST_RESULT;
          end
        end
        if (done_press) begin
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (done_press) begin
          state_d = ST_START;
        end
      end

      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_START;
      wr_count_q  <= '0;
      rd_ptr_q    <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      grade_q     <= 2'b00;
      overflow_q  <= 1'b0;
      grade_stb_q <= 1'b0;
      p1_clear_q  <= 1'b0;
      p2_clear_q  <= 1'b0;
      tick_cnt_q  <= '0;
      next_s1_q   <= 1'b1;
      next_s2_q   <= 1'b1;
      next_s3_q   <= 1'b1;
      done_s1_q   <= 1'b1;
      done_s2_q   <= 1'b1;
      done_s3_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      rd_ptr_q    <= rd_ptr_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      grade_q     <= grade_d;
      overflow_q  <= overflow_d;
      grade_stb_q <= grade_stb_d;
      p1_clear_q  <= p1_clear_d;
      p2_clear_q  <= p2_clear_d;
      tick_cnt_q  <= tick_cnt_d;
      next_s1_q   <= bus.next_n;
      next_s2_q   <= next_s1_q;
      next_s3_q   <= next_s2_q;
      done_s1_q   <= bus.done_n;
      done_s2_q   <= done_s1_q;
      done_s3_q   <= done_s2_q;
    end
  end

  // Buffer contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (resetn && mem_we) begin
      mem_q[wr_count_q[ADDR_W-1:0]] <= bus.p1_value;
    end
  end

  assign bus.state     = state_q;
  assign bus.tick_en   = tick;
  assign bus.p1_en     = tick && (state_q == ST_P1);
  assign bus.p2_en     = tick && (state_q == ST_P2);
  assign bus.p1_clear  = p1_clear_q;
  assign bus.p2_clear  = p2_clear_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.rd_ptr    = rd_ptr_q;
  assign bus.expected  = expected;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.grade     = grade_q;
  assign bus.grade_stb = grade_stb_q;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.win       = (state_q == ST_RESULT) && (score_q == wr_count_q) && (wr_count_q != '0);

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Scenario bench for morse_round_ctrl: grade scoreboard plus per-feature directed checks.
module tb_morse_round_ctrl;
  localparam int CODE_W   = 10;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int TICK_DIV = 5;
  localparam int MAX_MISS = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  morse_round_ctrl_if #(.CODE_W(CODE_W), .ADDR_W(ADDR_W)) bus ();

  morse_round_ctrl #(
    .CODE_W(CODE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .TICK_DIV(TICK_DIV), .MAX_MISS(MAX_MISS)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total   = 0;
  int bad     = 0;
  int stb_cnt = 0;
  logic [1:0] exp_q [$];

  // Grade scoreboard: each P2 guess pushes its expected grade, each strobe pops one
  always @(negedge clock) begin
    if (bus.grade_stb === 1'b1) begin
      logic [1:0] eg;
      stb_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grade_stb_unexpected got=stb want=none");
      end else begin
        eg = exp_q.pop_front();
        if (bus.grade !== eg) begin
          bad++;
          $display("FAIL grade_value got=%b want=%b", bus.grade, eg);
        end
      end
    end
  end

  task automatic press(input logic nx, input logic dn, input int hold);
    @(negedge clock);
    bus.next_n = ~nx;
    bus.done_n = ~dn;
    repeat (hold) @(negedge clock);
    bus.next_n = 1'b1;
    bus.done_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic store(input logic [CODE_W-1:0] v);
    bus.p1_value = v;
    press(1'b1, 1'b0, 4);
  endtask

  task automatic guess(input logic [CODE_W-1:0] v, input logic [1:0] g);
    bus.p2_value = v;
    exp_q.push_back(g);
    press(1'b1, 1'b0, 4);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    total++; if (bus.wr_count !== 3'd0 || bus.score !== 3'd0 || bus.misses !== 3'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", bus.wr_count, bus.score, bus.misses); end
    total++; if (bus.grade !== 2'b00 || bus.overflow !== 1'b0 || bus.tick_en !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b/%b/%b want=00/0/0", bus.grade, bus.overflow, bus.tick_en); end
    // Reach mid-P2 with a graded guess, then pull reset
    press(1'b0, 1'b1, 4);
    store(10'h0F0);
    store(10'h00F);
    press(1'b0, 1'b1, 4);
    guess(10'h0F0, 2'b01);
    total++; if (bus.state !== 2'd2 || bus.score !== 3'd1) begin
      bad++; $display("FAIL pre_reset got=state%0d score%0d want=state2 score1", bus.state, bus.score); end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (bus.state !== 2'd0 || bus.p1_clear !== 1'b0 || bus.p2_clear !== 1'b0 || bus.grade_stb !== 1'b0 ||
          bus.tick_en !== 1'b0 || bus.p1_en !== 1'b0 || bus.p2_en !== 1'b0) begin
        bad++; $display("FAIL in_reset cycle=%0d got=state%0d pulses=%b%b%b%b want=state0 pulses=0000", i, bus.state,
                        bus.p1_clear, bus.p2_clear, bus.grade_stb, bus.tick_en);
      end
    end
    resetn = 1'b1;
    total++; if (bus.score !== 3'd0 || bus.misses !== 3'd0 || bus.wr_count !== 3'd0 || bus.rd_ptr !== 3'd0) begin
      bad++; $display("FAIL post_reset_counts got=%0d/%0d/%0d/%0d want=0/0/0/0", bus.score, bus.misses, bus.wr_count, bus.rd_ptr); end
    total++; if (bus.grade !== 2'b00) begin bad++; $display("FAIL post_reset_grade got=%b want=00", bus.grade); end
  endtask

  task automatic test_round();
    stb_cnt = 0;
    press(1'b0, 1'b1, 4);
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL round_p1 got=%0d want=1", bus.state); end
    store(10'h155);
    store(10'h2AA);
    total++; if (bus.wr_count !== 3'd2) begin bad++; $display("FAIL round_wr got=%0d want=2", bus.wr_count); end
    press(1'b0, 1'b1, 4);
    total++; if (bus.state !== 2'd2 || bus.expected !== 10'h155) begin
      bad++; $display("FAIL round_p2 got=state%0d exp=%h want=state2 exp=155", bus.state, bus.expected); end
    guess(10'h155, 2'b01);
    guess(10'h000, 2'b10);
    total++; if (bus.score !== 3'd1 || bus.misses !== 3'd1) begin
      bad++; $display("FAIL round_score got=%0d/%0d want=1/1", bus.score, bus.misses); end
    total++; if (bus.grade !== 2'b10 || bus.state !== 2'd3 || bus.win !== 1'b0) begin
      bad++; $display("FAIL round_end got=grade%b state%0d win%b want=grade10 state3 win0", bus.grade, bus.state, bus.win); end
    total++; if (stb_cnt !== 2) begin bad++; $display("FAIL round_stb_count got=%0d want=2", stb_cnt); end
    press(1'b0, 1'b1, 4);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL round_restart got=%0d want=0", bus.state); end
  endtask

  task automatic test_full();
    logic [CODE_W-1:0] vals [5];
    vals[0] = 10'h011; vals[1] = 10'h122; vals[2] = 10'h233; vals[3] = 10'h344; vals[4] = 10'h3FF;
    press(1'b0, 1'b1, 4);
    for (int i = 0; i < 5; i++) store(vals[i]);
    total++; if (bus.wr_count !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      bad++; $display("FAIL full_flags got=wr%0d full%b ovf%b want=wr4 full1 ovf1", bus.wr_count, bus.full, bus.overflow); end
    press(1'b0, 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.expected !== vals[i]) begin bad++; $display("FAIL full_mem%0d got=%h want=%h", i, bus.expected, vals[i]); end
      guess(vals[i], 2'b01);
    end
    total++; if (bus.rd_ptr !== 3'd3 || bus.expected !== vals[3]) begin
      bad++; $display("FAIL full_mem3 got=ptr%0d %h want=ptr3 %h", bus.rd_ptr, bus.expected, vals[3]); end
    guess(vals[3], 2'b01);
    total++; if (bus.state !== 2'd3 || bus.win !== 1'b1 || bus.expected !== 10'h000) begin
      bad++; $display("FAIL full_win got=state%0d win%b exp=%h want=state3 win1 exp=000", bus.state, bus.win, bus.expected); end
    press(1'b0, 1'b1, 4);
  endtask

  task automatic test_miss_limit();
    logic [CODE_W-1:0] vals [4];
    vals[0] = 10'h0A5; vals[1] = 10'h15A; vals[2] = 10'h2C3; vals[3] = 10'h03C;
    press(1'b0, 1'b1, 4);
    press(1'b0, 1'b1, 4);
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL empty_done got=%0d want=1", bus.state); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", bus.overflow); end
    for (int i = 0; i < 4; i++) store(vals[i]);
    press(1'b0, 1'b1, 4);
    guess(vals[0] ^ 10'h001, 2'b10);
    total++; if (bus.state !== 2'd2 || bus.misses !== 3'd1 || bus.rd_ptr !== 3'd1) begin
      bad++; $display("FAIL miss1 got=state%0d miss%0d ptr%0d want=state2 miss1 ptr1", bus.state, bus.misses, bus.rd_ptr); end
    guess(vals[1] ^ 10'h200, 2'b10);
    total++; if (bus.state !== 2'd3 || bus.misses !== 3'd2 || bus.rd_ptr !== 3'd2) begin
      bad++; $display("FAIL miss2 got=state%0d miss%0d ptr%0d want=state3 miss2 ptr2", bus.state, bus.misses, bus.rd_ptr); end
    press(1'b0, 1'b1, 4);
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b1, 4);
    store(10'h1E1);
    bus.p1_value = 10'h0D2;
    press(1'b1, 1'b1, 4);
    total++; if (bus.wr_count !== 3'd2 || bus.state !== 2'd2) begin
      bad++; $display("FAIL sim_p1 got=wr%0d state%0d want=wr2 state2", bus.wr_count, bus.state); end
    bus.p2_value = 10'h1E1;
    exp_q.push_back(2'b01);
    press(1'b1, 1'b1, 4);
    total++; if (bus.state !== 2'd3 || bus.score !== 3'd1 || bus.rd_ptr !== 3'd1) begin
      bad++; $display("FAIL sim_p2 got=state%0d score%0d ptr%0d want=state3 score1 ptr1", bus.state, bus.score, bus.rd_ptr); end
    press(1'b0, 1'b1, 4);
  endtask

  task automatic test_debounce_tick();
    int n1, n2, nt, last;
    press(1'b0, 1'b1, 4);
    bus.p1_value = 10'h777;
    press(1'b1, 1'b0, 100);
    total++; if (bus.wr_count !== 3'd1) begin bad++; $display("FAIL hold_once got=%0d want=1", bus.wr_count); end
    n1 = 0; n2 = 0; last = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (bus.p2_en === 1'b1) n2++;
      if (bus.p1_en === 1'b1) begin
        if (last >= 0) begin
          total++; if (i - last !== TICK_DIV) begin bad++; $display("FAIL tick_gap got=%0d want=%0d", i - last, TICK_DIV); end
        end
        last = i;
        n1++;
      end
    end
    total++; if (n1 !== 5 || n2 !== 0) begin bad++; $display("FAIL p1_en_count got=%0d/%0d want=5/0", n1, n2); end
    press(1'b0, 1'b1, 4);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (bus.p1_en === 1'b1) n1++;
      if (bus.p2_en === 1'b1) n2++;
    end
    total++; if (n1 !== 0 || n2 !== 5) begin bad++; $display("FAIL p2_en_count got=%0d/%0d want=0/5", n1, n2); end
    press(1'b0, 1'b1, 4);
    press(1'b0, 1'b1, 4);
    n1 = 0; nt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (bus.p1_en === 1'b1 || bus.p2_en === 1'b1) n1++;
      if (bus.tick_en === 1'b1) nt++;
    end
    total++; if (bus.state !== 2'd0 || n1 !== 0 || nt !== 5) begin
      bad++; $display("FAIL start_tick got=state%0d en%0d tick%0d want=state0 en0 tick5", bus.state, n1, nt); end
  endtask

  initial begin
    bus.next_n   = 1'b1;
    bus.done_n   = 1'b1;
    bus.p1_value = '0;
    bus.p2_value = '0;
    test_reset();
    test_round();
    test_full();
    test_miss_limit();
    test_simultaneous();
    test_debounce_tick();
    repeat (4) @(negedge clock);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL grade_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
